// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
// Provides the decode->fetch PC-source encodings, the default reset PC
// and the fetch FSM state type used by fetch_unit.
package fetch_unit_pkg;

  // Width of decode's pc_src bus; wider than the four defined sources so
  // that unassigned encodings exist and fall back to sequential fetch.
  localparam int W_PC_SRC = 3;

  localparam logic [W_PC_SRC-1:0] PC_SRC_NEXT = 3'd0;
  localparam logic [W_PC_SRC-1:0] PC_SRC_JUMP = 3'd1;
  localparam logic [W_PC_SRC-1:0] PC_SRC_BRAN = 3'd2;
  localparam logic [W_PC_SRC-1:0] PC_SRC_REGF = 3'd3;

  // Text segment base.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

  // ST_HALT is only entered when the misalignment trap is built in.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_next_pc_calc.sv
// Next-PC target selection: sequential, jump, branch or register target.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when the result is used.
// Ports: pc_plus4/pc_src/jaddr/br_imm/br_taken/reg_target in, next_pc out
// (raw target, low bits not yet forced).
module fetch_unit_next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int W_CPU   = 32,
  parameter int W_JADDR = 26,
  parameter int W_IMM   = 16
) (
  input  logic [W_CPU-1:0]    pc_plus4,
  input  logic [W_PC_SRC-1:0] pc_src,
  input  logic [W_JADDR-1:0]  jaddr,
  input  logic [W_IMM-1:0]    br_imm,
  input  logic                br_taken,
  input  logic [W_CPU-1:0]    reg_target,
  output logic [W_CPU-1:0]    next_pc
);

  logic [W_CPU-1:0] imm_sext;
  logic [W_CPU-1:0] br_target;
  logic [W_CPU-1:0] jmp_target;

  always_comb begin
    imm_sext  = {{(W_CPU-W_IMM){br_imm[W_IMM-1]}}, br_imm};
    // Branch offset counts words relative to the delay-free pc+4.
    br_target = pc_plus4 + (imm_sext << 2);
    // Jump keeps the top region bits of pc+4 and replaces the rest.
    jmp_target = {pc_plus4[W_CPU-1 -: (W_CPU-W_JADDR-2)], jaddr, 2'b00};

    case (pc_src)
      PC_SRC_NEXT: next_pc = pc_plus4;
      PC_SRC_JUMP: next_pc = jmp_target;
      PC_SRC_BRAN: next_pc = br_taken ? br_target : pc_plus4;
      PC_SRC_REGF: next_pc = reg_target;
      default:     next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem reads, holds inst for decode.
// Latency: 2 cycles minimum per instruction (REQ with immediate ready, then HOLD).
// Backpressure: inst/pc held while stall==1; no new request until consumed.
// Ports: clk, rst (sync, active-low); imem_req/addr/ready/rdata memory side;
// inst/inst_valid/pc/pc_plus4/stall and redirect inputs (pc_src, jaddr,
// br_imm, br_taken, reg_target) decode side.
// Build option FETCH_MISALIGN_TRAP_EN: adds fetch_err and a HALT state on a
// misaligned next PC; otherwise the low PC bits are forced to zero.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          W_CPU    = 32,
  parameter int          W_JADDR  = 26,
  parameter int          W_IMM    = 16,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [W_CPU-1:0]    imem_addr,
  input  logic                imem_ready,
  input  logic [W_CPU-1:0]    imem_rdata,
  output logic [W_CPU-1:0]    inst,
  output logic                inst_valid,
  output logic [W_CPU-1:0]    pc,
  output logic [W_CPU-1:0]    pc_plus4,
  input  logic                stall,
  input  logic [W_PC_SRC-1:0] pc_src,
  input  logic [W_JADDR-1:0]  jaddr,
  input  logic [W_IMM-1:0]    br_imm,
  input  logic                br_taken,
  input  logic [W_CPU-1:0]    reg_target
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                fetch_err
`endif
);

  fetch_state_e     state_q, state_d;
  logic [W_CPU-1:0] pc_q, pc_d;
  logic [W_CPU-1:0] inst_q, inst_d;
  logic [W_CPU-1:0] next_pc_raw;
  logic [W_CPU-1:0] next_pc_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic             fetch_err_q, fetch_err_d;
`endif

  assign pc_plus4 = pc_q + W_CPU'(4);

  fetch_unit_next_pc_calc #(
    .W_CPU   (W_CPU),
    .W_JADDR (W_JADDR),
    .W_IMM   (W_IMM)
  ) u_next_pc_calc (
    .pc_plus4   (pc_plus4),
    .pc_src     (pc_src),
    .jaddr      (jaddr),
    .br_imm     (br_imm),
    .br_taken   (br_taken),
    .reg_target (reg_target),
    .next_pc    (next_pc_raw)
  );

  assign next_pc_aligned = next_pc_raw & {{(W_CPU-2){1'b1}}, 2'b00};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch_err_d = fetch_err_q;
`endif

    case (state_q)
      ST_REQ, ST_WAIT: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          inst_d  = imem_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        inst_valid = 1'b1;
        // Redirect inputs only matter in the consume cycle.
        if (!stall) begin
          state_d = ST_REQ;
          pc_d    = next_pc_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (next_pc_raw[1:0] != 2'b00) begin
            pc_d        = next_pc_raw;
            fetch_err_d = 1'b1;
            state_d     = ST_HALT;
          end
`endif
        end
      end
      default: begin
        // ST_HALT: idle until reset.
      end
    endcase

    // A reset cycle must not present a request or a valid instruction;
    // dropping req also tells memory to abandon any pending read.
    if (!rst) begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_REQ;
      pc_q    <= W_CPU'(RESET_PC);
      inst_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_err_q <= fetch_err_d;
`endif
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_err = fetch_err_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model (expected PC, memory contents as a
// function of address, next-PC computed arithmetically).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic [2:0]  pc_src;
  logic [25:0] jaddr;
  logic [15:0] br_imm;
  logic        br_taken;
  logic [31:0] reg_target;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_err;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .stall      (stall),
    .pc_src     (pc_src),
    .jaddr      (jaddr),
    .br_imm     (br_imm),
    .br_taken   (br_taken),
    .reg_target (reg_target)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_err  (fetch_err)
`endif
  );

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Architectural next-PC rule, before any alignment handling.
  function automatic logic [31:0] ref_target(input logic [2:0] src, input logic [31:0] cur,
                                             input logic [25:0] ja, input logic [15:0] imm,
                                             input logic tk, input logic [31:0] rt);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = int'($signed(imm));
    case (src)
      3'd1:    return (seq & 32'hF000_0000) | (32'(ja) * 32'd4);
      3'd2:    return tk ? seq + 32'(off * 4) : seq;
      3'd3:    return rt;
      default: return seq;
    endcase
  endfunction

  task automatic drive_junk();
    pc_src     = 3'($urandom_range(0, 7));
    jaddr      = 26'($urandom);
    br_imm     = 16'($urandom);
    br_taken   = 1'($urandom_range(0, 1));
    reg_target = $urandom;
  endtask

  // One full instruction: request (with delay wait cycles), hold with
  // nstall stall cycles, then consume with the given redirect.
  task automatic do_fetch(input int delay, input int nstall, input logic [2:0] src,
                          input logic [25:0] ja, input logic [15:0] imm,
                          input logic tk, input logic [31:0] rt);
    logic [31:0] tgt;
    for (int c = 0; c <= delay; c++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc) begin
        bad++;
        $display("FAIL req_addr: req=%0b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_pc);
      end
      total++;
      if (inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL valid_during_req: inst_valid=%0b, want 0", inst_valid);
      end
      imem_ready = (c == delay);
      imem_rdata = (c == delay) ? mem_word(exp_pc) : $urandom;
      stall      = 1'($urandom_range(0, 1));
      drive_junk();
      @(negedge clk);
    end
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    for (int k = 0; k <= nstall; k++) begin
      total++;
      if (inst_valid !== 1'b1 || inst !== mem_word(exp_pc)) begin
        bad++;
        $display("FAIL hold_inst: valid=%0b inst=%h, want valid=1 inst=%h", inst_valid, inst, mem_word(exp_pc));
      end
      total++;
      if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        bad++;
        $display("FAIL hold_pc: pc=%h pc_plus4=%h, want %h %h", pc, pc_plus4, exp_pc, exp_pc + 32'd4);
      end
      total++;
      if (imem_req !== 1'b0) begin
        bad++;
        $display("FAIL hold_no_req: imem_req=%0b, want 0", imem_req);
      end
      if (k < nstall) begin
        stall      = 1'b1;
        imem_ready = 1'($urandom_range(0, 1));
        drive_junk();
      end else begin
        stall      = 1'b0;
        imem_ready = 1'b0;
        pc_src     = src;
        jaddr      = ja;
        br_imm     = imm;
        br_taken   = tk;
        reg_target = rt;
      end
      @(negedge clk);
    end
    stall = 1'b0;
    tgt   = ref_target(src, exp_pc, ja, imm, tk, rt);
`ifdef FETCH_MISALIGN_TRAP_EN
    exp_pc = (tgt[1:0] != 2'b00) ? tgt : tgt;
`else
    exp_pc = {tgt[31:2], 2'b00};
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst        = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_cycle: req=%0b valid=%0b, want 0 0", imem_req, inst_valid);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || pc !== 32'h0040_0000) begin
      bad++;
      $display("FAIL reset_state: req=%0b addr=%h pc=%h, want 1 00400000", imem_req, imem_addr, pc);
    end
    total++;
    if (inst_valid !== 1'b0 || inst !== 32'h0) begin
      bad++;
      $display("FAIL reset_inst: valid=%0b inst=%h, want 0 0", inst_valid, inst);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    total++;
    if (fetch_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_err: fetch_err=%0b, want 0", fetch_err);
    end
`endif
    exp_pc = 32'h0040_0000;
  endtask

  task automatic test_sequential();
    test_reset();
    for (int i = 0; i < 3; i++) do_fetch(0, 0, PC_SRC_NEXT, 0, 0, 0, 0);
    total++;
    if (imem_addr !== 32'h0040_000C) begin
      bad++;
      $display("FAIL seq_addr: addr=%h, want 0040000c", imem_addr);
    end
  endtask

  task automatic test_mem_delay();
    do_fetch(3, 0, PC_SRC_NEXT, 0, 0, 0, 0);
  endtask

  task automatic test_stall();
    do_fetch(0, 5, PC_SRC_NEXT, 0, 0, 0, 0);
  endtask

  task automatic test_redirect();
    logic [31:0] want [4];
    want[0] = 32'h0040_0004;
    want[1] = 32'h0040_0014;
    want[2] = 32'h0040_000C;
    want[3] = 32'h0040_0100;
    for (int i = 0; i < 4; i++) begin
      do_fetch(0, 0, PC_SRC_REGF, 0, 0, 0, 32'h0040_0010);
      case (i)
        0: do_fetch(1, 1, PC_SRC_BRAN, 0, 16'hFFFC, 1'b1, 0);
        1: do_fetch(0, 0, PC_SRC_BRAN, 0, 16'hFFFC, 1'b0, 0);
        2: do_fetch(0, 2, PC_SRC_JUMP, 26'h010_0003, 0, 0, 0);
        default: do_fetch(2, 0, PC_SRC_REGF, 0, 0, 0, 32'h0040_0100);
      endcase
      total++;
      if (imem_addr !== want[i]) begin
        bad++;
        $display("FAIL redirect_%0d: addr=%h, want %h", i, imem_addr, want[i]);
      end
    end
  endtask

  task automatic test_wrap();
    do_fetch(0, 0, PC_SRC_REGF, 0, 0, 0, 32'hFFFF_FFFC);
    do_fetch(0, 0, PC_SRC_NEXT, 0, 0, 0, 0);
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap: addr=%h, want 00000000", imem_addr);
    end
    do_fetch(0, 0, PC_SRC_NEXT, 0, 0, 0, 0);
  endtask

  task automatic test_reset_in_wait();
    do_fetch(0, 0, PC_SRC_REGF, 0, 0, 0, 32'h0040_0200);
    imem_ready = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0200) begin
      bad++;
      $display("FAIL wait_req: req=%0b addr=%h, want 1 00400200", imem_req, imem_addr);
    end
    rst        = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    rst        = 1'b1;
    imem_ready = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0000 || inst_valid !== 1'b0 || inst !== 32'h0) begin
      bad++;
      $display("FAIL reset_wait: req=%0b addr=%h valid=%0b inst=%h, want 1 00400000 0 0",
               imem_req, imem_addr, inst_valid, inst);
    end
    exp_pc = 32'h0040_0000;
    do_fetch(1, 0, PC_SRC_NEXT, 0, 0, 0, 0);
  endtask

  task automatic test_misalign();
    do_fetch(0, 0, PC_SRC_REGF, 0, 0, 0, 32'h0040_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 6; i++) begin
      total++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        bad++;
        $display("FAIL halt: err=%0b req=%0b valid=%0b, want 1 0 0", fetch_err, imem_req, inst_valid);
      end
      imem_ready = 1'($urandom_range(0, 1));
      stall      = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    total++;
    if (pc !== 32'h0040_0102) begin
      bad++;
      $display("FAIL halt_pc: pc=%h, want 00400102", pc);
    end
    imem_ready = 1'b0;
    test_reset();
`else
    total++;
    if (imem_addr !== 32'h0040_0100) begin
      bad++;
      $display("FAIL misalign_force: addr=%h, want 00400100", imem_addr);
    end
    do_fetch(0, 0, PC_SRC_NEXT, 0, 0, 0, 0);
`endif
  endtask

  task automatic test_random();
    logic [31:0] rt;
    for (int i = 0; i < 150; i++) begin
      rt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rt[1:0] = 2'b00;
`endif
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom_range(0, 5)),
               26'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rt);
    end
  endtask

  initial begin
    rst        = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    stall      = 1'b0;
    pc_src     = PC_SRC_NEXT;
    jaddr      = '0;
    br_imm     = '0;
    br_taken   = 1'b0;
    reg_target = '0;
    exp_pc     = 32'h0040_0000;
    repeat (2) @(negedge clk);
    test_sequential();
    test_mem_delay();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_in_wait();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
